// File: rtl/mantis_pkg.sv
// mantis_pkg: shared widths and FSM state type for the MANTIS core arbiter
//   DATA_W : plaintext/ciphertext width
//   TW_W   : tweak width
//   KEY_W  : key width
//   state_t: arbiter FSM states
package mantis_pkg;
   localparam int DATA_W = 64;
   localparam int TW_W   = 64;
   localparam int KEY_W  = 128;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/mantis_arbiter_if.sv
// mantis_arbiter_if: requester, response and cipher-core signals of the arbiter
//   req/req_data/req_tw/req_key : per-requester request level and operands (slice i)
//   grant                       : one-hot grant, operands captured at that edge
//   rsp_valid/rsp_id/rsp_data/rsp_err/rsp_ready : tagged response handshake
//   core_start/core_data/core_tw/core_key       : start pulse and latched operands to the core
//   core_busy/core_done/core_rdata              : core status, done pulse and ciphertext
//   master = arbiter side, slave = requester fabric and core side
interface mantis_arbiter_if #(parameter int N = 4);
   import mantis_pkg::*;
   logic [N-1:0]          req;
   logic [N*DATA_W-1:0]   req_data;
   logic [N*TW_W-1:0]     req_tw;
   logic [N*KEY_W-1:0]    req_key;
   logic [N-1:0]          grant;
   logic                  rsp_valid;
   logic [$clog2(N)-1:0]  rsp_id;
   logic [DATA_W-1:0]     rsp_data;
   logic                  rsp_err;
   logic                  rsp_ready;
   logic                  core_start;
   logic [DATA_W-1:0]     core_data;
   logic [TW_W-1:0]       core_tw;
   logic [KEY_W-1:0]      core_key;
   logic                  core_busy;
   logic                  core_done;
   logic [DATA_W-1:0]     core_rdata;
   modport master (
      input  req, req_data, req_tw, req_key, rsp_ready, core_busy, core_done, core_rdata,
      output grant, rsp_valid, rsp_id, rsp_data, rsp_err, core_start, core_data, core_tw, core_key
   );
   modport slave (
      output req, req_data, req_tw, req_key, rsp_ready, core_busy, core_done, core_rdata,
      input  grant, rsp_valid, rsp_id, rsp_data, rsp_err, core_start, core_data, core_tw, core_key
   );
endinterface

// File: rtl/mantis_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, searching from ptr+1 upward with wrap
//   req   : request vector
//   ptr   : index of the most recently served requester
//   grant : one-hot pick (zero when no request)
//   idx   : encoded pick (zero when no request)
module rr_picker #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx
);
   localparam int IDW = $clog2(N);
   logic hit;
   int   j;
   // Walk from the farthest candidate to the nearest so the nearest hit wins.
   always_comb begin
      idx = '0;
      hit = 1'b0;
      j   = 0;
      for (int k = N; k > 0; k--) begin
         j = int'(ptr) + k;
         j = (j >= N) ? j - N : j;
         if (req[j]) begin
            idx = IDW'(j);
            hit = 1'b1;
         end
      end
   end
   assign grant = {N{hit}} & (N'(1) << idx);
endmodule

// File: rtl/mantis_arbiter.sv
// mantis_arbiter: round-robin sharing of one MANTIS tweakable block-cipher core among N requesters
//   i_Clk   : clock
//   i_Reset : asynchronous active-low reset
//   bus     : requester operands/grant, tagged response handshake and core start/done handshake
//   N       : number of requesters (2..16)
//   TIMEOUT : cycles allowed in WAIT before an error response (>= 2)
module mantis_arbiter
   import mantis_pkg::*;
#(
   parameter int N       = 4,
   parameter int TIMEOUT = 64
) (
   input logic              i_Clk,
   input logic              i_Reset,
   mantis_arbiter_if.master bus
);
   localparam int IDW = $clog2(N);
   localparam int TMW = $clog2(TIMEOUT);
   localparam logic [TMW-1:0] T_LAST = TMW'(TIMEOUT - 1);
   localparam logic [TMW-1:0] T_MAX  = '1;
   state_t            state, state_nx;
   logic [IDW-1:0]    ptr, id, pick;
   logic [N-1:0]      pick_oh;
   logic [TMW-1:0]    timer;
   logic [DATA_W-1:0] op_data, rsp_data;
   logic [TW_W-1:0]   op_tw;
   logic [KEY_W-1:0]  op_key;
   logic              rsp_err;
   logic              any_req, timed_out;
   rr_picker #(.N(N)) u_pick (
      .req   (bus.req),
      .ptr   (ptr),
      .grant (pick_oh),
      .idx   (pick)
   );
   assign any_req   = |bus.req;
   assign timed_out = timer == T_LAST;
   assign bus.core_data = op_data;
   assign bus.core_tw   = op_tw;
   assign bus.core_key  = op_key;
   assign bus.rsp_id    = id;
   assign bus.rsp_data  = rsp_data;
   assign bus.rsp_err   = rsp_err;
   // core_busy is status only; the FSM relies solely on core_done and the watchdog.
   always_comb begin
      state_nx       = state;
      bus.grant      = '0;
      bus.core_start = 1'b0;
      bus.rsp_valid  = 1'b0;
      case (state)
         IDLE: begin
            state_nx  = any_req ? ISSUE : IDLE;
            bus.grant = pick_oh;
         end
         ISSUE: begin
            state_nx       = WAIT;
            bus.core_start = 1'b1;
         end
         WAIT:    state_nx = (bus.core_done || timed_out) ? RESP : WAIT;
         RESP: begin
            state_nx      = bus.rsp_ready ? IDLE : RESP;
            bus.rsp_valid = 1'b1;
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge i_Clk or negedge i_Reset) begin
      if (!i_Reset) begin
         state    <= IDLE;
         ptr      <= IDW'(N - 1);
         id       <= '0;
         timer    <= '0;
         op_data  <= '0;
         op_tw    <= '0;
         op_key   <= '0;
         rsp_data <= '0;
         rsp_err  <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && any_req) begin
            id      <= pick;
            op_data <= bus.req_data[DATA_W*pick +: DATA_W];
            op_tw   <= bus.req_tw[TW_W*pick +: TW_W];
            op_key  <= bus.req_key[KEY_W*pick +: KEY_W];
         end
         if (state == ISSUE) timer <= '0;
         if (state == WAIT) begin
            timer <= (timer == T_MAX) ? timer : timer + TMW'(1);
            // A done pulse in the timeout cycle still delivers the real result.
            if (bus.core_done) begin
               rsp_data <= bus.core_rdata;
               rsp_err  <= 1'b0;
            end else if (timed_out) begin
               rsp_data <= '0;
               rsp_err  <= 1'b1;
            end
         end
         // Priority moves only on acceptance, so a timed-out requester also yields.
         if (state == RESP && bus.rsp_ready) ptr <= id;
      end
   end
endmodule

// File: tb/tb_mantis_arbiter.sv
// tb_mantis_arbiter: randomized transaction-level check of mantis_arbiter against a timeline model
module tb_mantis_arbiter;
   localparam int N  = 4;
   localparam int TO = 64;
   logic i_Clk = 1'b0;
   logic i_Reset = 1'b0;
   always #5 i_Clk = ~i_Clk;
   mantis_arbiter_if #(.N(N)) bus ();
   mantis_arbiter #(.N(N), .TIMEOUT(TO)) dut (
      .i_Clk   (i_Clk),
      .i_Reset (i_Reset),
      .bus     (bus)
   );
   // core stub: done pulse stub_lat cycles after the start cycle (0 = never), result = data ^ tweak
   int          stub_lat = 20;
   int          cnt = 0;
   logic [63:0] stub_val = '0;
   always @(posedge i_Clk) begin
      if (bus.core_start) begin
         cnt      <= stub_lat;
         stub_val <= bus.core_data ^ bus.core_tw;
      end else if (cnt != 0) cnt <= cnt - 1;
   end
   assign bus.core_done  = (cnt == 1);
   assign bus.core_rdata = bus.core_done ? stub_val : ~stub_val;
   assign bus.core_busy  = (cnt != 0);
   int           n_cmp = 0, n_bad = 0, cyc = 0;
   logic [N-1:0] clr = '0, pend = '0, hold = '0;
   logic         rdy_nxt = 1'b1;
   bit           busy = 0;
   int           g_cyc = 0, rsp_cyc = 0, m_ptr = N - 1, e_id = 0;
   logic [63:0]  e_d = '0, e_t = '0, e_data = '0;
   logic [127:0] e_k = '0;
   logic         e_err = 1'b0;
   int           gq[$];
   int           n_start = 0, n_grant = 0, n_valid = 0;
   int           t_start = 0, t_done = 0, t_valid = 0, rsp_lat = 0;
   logic         prev_v = 1'b0;
   logic [63:0]  last_data = '0;
   logic         last_err = 1'b0;
   int           exp_o[5] = '{0, 1, 2, 3, 0};
   int           s = 0;
   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask
   function automatic int m_pick(logic [N-1:0] r, int p);
      for (int k = 1; k <= N; k++) if (r[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction
   task automatic set_ops(int i, logic [63:0] d, logic [63:0] t, logic [127:0] k);
      bus.req_data[64*i +: 64] = d;
      bus.req_tw[64*i +: 64]   = t;
      bus.req_key[128*i +: 128] = k;
   endtask
   task automatic new_ops(int i);
      set_ops(i, {$urandom(), $urandom()}, {$urandom(), $urandom()},
              {$urandom(), $urandom(), $urandom(), $urandom()});
   endtask
   task automatic raise(int i, logic [63:0] d, logic [63:0] t, logic [127:0] k);
      set_ops(i, d, t, k);
      pend[i] = 1'b1;
   endtask
   task automatic raise_rnd(int i);
      new_ops(i);
      pend[i] = 1'b1;
   endtask
   task automatic step();
      logic [N-1:0] eg;
      logic ev, ok;
      int j;
      @(posedge i_Clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (clr[i]) begin
            if (hold[i]) new_ops(i);
            else bus.req[i] = 1'b0;
         end
         if (pend[i]) bus.req[i] = 1'b1;
      end
      clr = '0;
      pend = '0;
      bus.rsp_ready = rdy_nxt;
      #2;
      eg = '0;
      j = m_pick(bus.req, m_ptr);
      if (!busy && j >= 0) eg[j] = 1'b1;
      ev = busy && cyc >= rsp_cyc;
      chk("grant", bus.grant, eg);
      chk("core_start", bus.core_start, busy && cyc == g_cyc + 1);
      chk("rsp_valid", bus.rsp_valid, ev);
      chk("core_ops", {bus.core_data, bus.core_tw, bus.core_key[63:0]}, {e_d, e_t, e_k[63:0]});
      if (ev) begin
         chk("rsp_id", bus.rsp_id, e_id);
         chk("rsp_data", bus.rsp_data, e_data);
         chk("rsp_err", bus.rsp_err, e_err);
      end
      if (bus.core_start) begin n_start++; t_start = cyc; end
      if (bus.core_done) t_done = cyc;
      if (|bus.grant) n_grant++;
      if (bus.rsp_valid && !prev_v) begin t_valid = cyc; rsp_lat = cyc - t_start; n_valid++; end
      prev_v = bus.rsp_valid;
      if (bus.rsp_valid && bus.rsp_ready) begin last_data = bus.rsp_data; last_err = bus.rsp_err; end
      if (|eg) begin
         busy = 1;
         g_cyc = cyc;
         e_id = j;
         e_d = bus.req_data[64*j +: 64];
         e_t = bus.req_tw[64*j +: 64];
         e_k = bus.req_key[128*j +: 128];
         ok = stub_lat != 0 && stub_lat <= TO;
         rsp_cyc = cyc + 1 + (ok ? stub_lat : TO) + 1;
         e_err = !ok;
         e_data = ok ? e_d ^ e_t : 64'd0;
         clr[j] = 1'b1;
         gq.push_back(j);
      end else if (ev && bus.rsp_ready) begin
         busy = 0;
         m_ptr = e_id;
      end
   endtask
   task automatic run(int n);
      repeat (n) step();
   endtask
   task automatic do_reset();
      @(posedge i_Clk);
      #1;
      cyc++;
      i_Reset = 1'b0;
      bus.req = '0;
      clr = '0;
      pend = '0;
      #2;
      chk("rst_grant", bus.grant, 0);
      chk("rst_valid", bus.rsp_valid, 0);
      chk("rst_start", bus.core_start, 0);
      chk("rst_err", bus.rsp_err, 0);
      chk("rst_id", bus.rsp_id, 0);
      chk("rst_rdata", bus.rsp_data, 0);
      chk("rst_core_ops", {bus.core_data, bus.core_tw}, 0);
      chk("rst_core_key", bus.core_key, 0);
      busy = 0;
      m_ptr = N - 1;
      e_d = '0;
      e_t = '0;
      e_k = '0;
      prev_v = 1'b0;
      @(posedge i_Clk);
      #1;
      cyc++;
      i_Reset = 1'b1;
   endtask
   initial begin
      bus.req = '0;
      bus.req_data = '0;
      bus.req_tw = '0;
      bus.req_key = '0;
      bus.rsp_ready = 1'b1;
      do_reset();
      n_start = 0;
      raise(2, 64'h0123456789ABCDEF, 64'h1111111111111111, {$urandom(), $urandom(), $urandom(), $urandom()});
      run(25);
      chk("s1_grant_id", gq[gq.size()-1], 2);
      chk("s1_starts", n_start, 1);
      chk("s1_data", last_data, 64'h1032547698BADCFE);
      chk("s1_err", last_err, 0);
      chk("s1_lat", rsp_lat, 21);
      chk("s1_done_to_valid", t_valid - t_done, 1);
      do_reset();
      s = gq.size();
      hold = '1;
      for (int i = 0; i < N; i++) raise_rnd(i);
      run(5 * 23);
      hold = '0;
      run(4 * 23 + 5);
      for (int k = 0; k < 5; k++) chk("s2_order", gq[s + k], exp_o[k]);
      rdy_nxt = 1'b0;
      raise_rnd(1);
      run(5);
      raise_rnd(3);
      n_grant = 0;
      run(27);
      chk("s3_bp_grants", n_grant, 0);
      chk("s3_bp_valid", bus.rsp_valid, 1);
      rdy_nxt = 1'b1;
      run(50);
      chk("s3_next_grant", gq[gq.size()-1], 3);
      s = gq.size();
      stub_lat = 0;
      raise_rnd(1);
      run(5);
      stub_lat = 20;
      raise_rnd(0);
      raise_rnd(2);
      run(70);
      chk("s4_timeout_lat", rsp_lat, 65);
      chk("s4_err", last_err, 1);
      chk("s4_data", last_data, 0);
      chk("s4_failed_id", gq[s], 1);
      chk("s4_next_id", gq[s + 1], 2);
      run(60);
      stub_lat = 64;
      raise_rnd(3);
      run(70);
      chk("s5_coinc_err", last_err, 0);
      chk("s5_coinc_lat", rsp_lat, 65);
      chk("s5_coinc_data", last_data, e_data);
      stub_lat = 70;
      raise_rnd(0);
      run(100);
      chk("s5_late_err", last_err, 1);
      do_reset();
      stub_lat = 20;
      n_valid = 0;
      raise_rnd(2);
      run(16);
      do_reset();
      run(30);
      chk("s6_no_rsp", n_valid, 0);
      raise_rnd(2);
      run(25);
      chk("s6_grant_id", gq[gq.size()-1], 2);
      chk("s6_err", last_err, 0);
      chk("s6_lat", rsp_lat, 21);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
